// File: rtl/booth_mul_iter.sv
// Iterative radix-4 Booth multiplier with per-operand signedness.
// DIGITS_PER_CYCLE Booth digits are retired per clock.
// Operands arrive and the product leaves on valid/ready handshakes.
module booth_mul_iter #(
    parameter int unsigned WIDTH            = 8,
    parameter int unsigned DIGITS_PER_CYCLE = 1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               flush_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    input  logic               a_unsigned_i,
    input  logic               b_unsigned_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [2*WIDTH-1:0] product_o
);

    localparam int unsigned ND  = WIDTH / 2 + 1;
    localparam int unsigned DPC = (DIGITS_PER_CYCLE == 0) ? 1 : DIGITS_PER_CYCLE;
    localparam int unsigned NI  = (ND + DPC - 1) / DPC;
    localparam int unsigned AW  = 2 * WIDTH + 2;
    localparam int unsigned BW  = WIDTH + 3;
    localparam int unsigned PW  = 2 * WIDTH;
    localparam int unsigned IW  = (NI > 1) ? $clog2(NI) : 1;
    localparam int unsigned SH  = 2 * DPC;

    // Reject parameter sets the datapath cannot represent
    if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
        $fatal(1, "booth_mul_iter: WIDTH must be even and >= 4");
    end
    if (DIGITS_PER_CYCLE < 1 || DIGITS_PER_CYCLE > ND) begin : g_bad_dpc
        $fatal(1, "booth_mul_iter: DIGITS_PER_CYCLE must be in 1..WIDTH/2+1");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic [PW-1:0]   product_q, product_d;
    logic [AW-1:0]   acc_q, acc_d;
    // Multiplicand, pre-shifted so bit 0 lines up with the current digit group
    logic [AW-1:0]   mc_q, mc_d;
    // Booth windows {ext, ext, b, 0}; shifting in ext makes trailing digits zero
    logic [BW-1:0]   bx_q, bx_d;
    logic [IW-1:0]   iter_q, iter_d;

    logic [AW-1:0]   acc_step;
    logic [AW-1:0]   pp;
    logic            a_fill;
    logic            b_fill;

    // Sum of this iteration's DPC Booth-digit partial products onto the accumulator
    always_comb begin
        acc_step = acc_q;
        pp       = '0;
        for (int j = 0; j < int'(DPC); j++) begin
            pp = mc_q << (2 * j);
            case (bx_q[2*j+2 -: 3])
                3'b001, 3'b010: acc_step = acc_step + pp;
                3'b011:         acc_step = acc_step + {pp[AW-2:0], 1'b0};
                3'b100:         acc_step = acc_step - {pp[AW-2:0], 1'b0};
                3'b101, 3'b110: acc_step = acc_step - pp;
                default:        acc_step = acc_step;
            endcase
        end
    end

    // Next-state, datapath and registered-output logic
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mc_d      = mc_q;
        bx_d      = bx_q;
        iter_d    = iter_q;
        product_d = product_q;
        a_fill    = ~a_unsigned_i & a_i[WIDTH-1];
        b_fill    = ~b_unsigned_i & b_i[WIDTH-1];

        case (state_q)
            S_IDLE: begin
                if (in_valid_i && in_ready_q && !flush_i) begin
                    acc_d   = '0;
                    mc_d    = {{(AW-WIDTH){a_fill}}, a_i};
                    bx_d    = {b_fill, b_fill, b_i, 1'b0};
                    iter_d  = '0;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                acc_d  = acc_step;
                mc_d   = mc_q << SH;
                bx_d   = BW'($signed(bx_q) >>> SH);
                iter_d = iter_q + 1'b1;
                if (iter_q == IW'(NI - 1)) begin
                    product_d = acc_step[PW-1:0];
                    iter_d    = '0;
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Flush wins over acceptance and delivery alike
        if (flush_i) begin
            state_d = S_IDLE;
            iter_d  = '0;
        end

        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
    end

    // State and datapath registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            product_q   <= '0;
            acc_q       <= '0;
            mc_q        <= '0;
            bx_q        <= '0;
            iter_q      <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            product_q   <= product_d;
            acc_q       <= acc_d;
            mc_q        <= mc_d;
            bx_q        <= bx_d;
            iter_q      <= iter_d;
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign product_o   = product_q;

endmodule

// File: tb/tb_booth_mul_iter.sv
// Bench for booth_mul_iter: three instances (DPC = 1, 2, 5) share one stimulus stream.
module tb_booth_mul_iter;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        flush_i;
    logic        in_valid_i;
    logic [7:0]  a_i;
    logic [7:0]  b_i;
    logic        a_unsigned_i;
    logic        b_unsigned_i;
    logic        out_ready_i;

    logic        rdy1, rdy2, rdy5;
    logic        vld1, vld2, vld5;
    logic [15:0] prod1, prod2, prod5;

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    booth_mul_iter #(.WIDTH(8), .DIGITS_PER_CYCLE(1)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(rdy1),
        .a_i(a_i), .b_i(b_i), .a_unsigned_i(a_unsigned_i), .b_unsigned_i(b_unsigned_i),
        .out_valid_o(vld1), .out_ready_i(out_ready_i), .product_o(prod1)
    );

    booth_mul_iter #(.WIDTH(8), .DIGITS_PER_CYCLE(2)) dut2 (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(rdy2),
        .a_i(a_i), .b_i(b_i), .a_unsigned_i(a_unsigned_i), .b_unsigned_i(b_unsigned_i),
        .out_valid_o(vld2), .out_ready_i(out_ready_i), .product_o(prod2)
    );

    booth_mul_iter #(.WIDTH(8), .DIGITS_PER_CYCLE(5)) dut5 (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(rdy5),
        .a_i(a_i), .b_i(b_i), .a_unsigned_i(a_unsigned_i), .b_unsigned_i(b_unsigned_i),
        .out_valid_o(vld5), .out_ready_i(out_ready_i), .product_o(prod5)
    );

    // Reference: exact integer product of the interpreted operands, low 16 bits
    function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b,
                                            input logic au, input logic bu);
        longint av;
        longint bv;
        av = au ? longint'(a) : longint'($signed(a));
        bv = bu ? longint'(b) : longint'($signed(b));
        return 16'(av * bv);
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Present one request for a single edge; operands are scrambled afterwards
    task automatic accept(input logic [7:0] a, input logic [7:0] b,
                          input logic au, input logic bu);
        a_i          = a;
        b_i          = b;
        a_unsigned_i = au;
        b_unsigned_i = bu;
        in_valid_i   = 1'b1;
        tick();
        in_valid_i   = 1'b0;
        a_i          = 8'($urandom);
        b_i          = 8'($urandom);
        a_unsigned_i = 1'($urandom);
        b_unsigned_i = 1'($urandom);
    endtask

    // Run one operation on all instances, recording product and latency of each
    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          input logic au, input logic bu,
                          output logic [15:0] p1, output logic [15:0] p2, output logic [15:0] p5,
                          output int l1, output int l2, output int l5);
        l1 = 0; l2 = 0; l5 = 0;
        p1 = 'x; p2 = 'x; p5 = 'x;
        accept(a, b, au, bu);
        for (int c = 1; c <= 20; c++) begin
            tick();
            a_i = 8'($urandom);
            b_i = 8'($urandom);
            if (vld1 && l1 == 0) begin l1 = c; p1 = prod1; end
            if (vld2 && l2 == 0) begin l2 = c; p2 = prod2; end
            if (vld5 && l5 == 0) begin l5 = c; p5 = prod5; end
            if (l1 != 0 && l2 != 0 && l5 != 0) break;
        end
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
        a_i = '0; b_i = '0; a_unsigned_i = 1'b0; b_unsigned_i = 1'b0;
        repeat (3) tick();
        total++; if (rdy1 !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", rdy1); end
        total++; if ({vld1, vld2, vld5} !== 3'b000) begin bad++; $display("FAIL reset_out_valid got=%b want=000", {vld1, vld2, vld5}); end
        total++; if (prod1 !== 16'h0) begin bad++; $display("FAIL reset_product got=%h want=0000", prod1); end
        rst_ni = 1'b1;
        tick();
    endtask

    // Directed operation: check all three products and latencies against the model
    task automatic check_op(input string name, input logic [7:0] a, input logic [7:0] b,
                            input logic au, input logic bu);
        logic [15:0] p1, p2, p5, exp;
        int l1, l2, l5;
        exp = ref_mul(a, b, au, bu);
        run_op(a, b, au, bu, p1, p2, p5, l1, l2, l5);
        total++; if (p1 !== exp) begin bad++; $display("FAIL %s dpc1 prod got=%h want=%h", name, p1, exp); end
        total++; if (p2 !== exp) begin bad++; $display("FAIL %s dpc2 prod got=%h want=%h", name, p2, exp); end
        total++; if (p5 !== exp) begin bad++; $display("FAIL %s dpc5 prod got=%h want=%h", name, p5, exp); end
        total++; if (l1 != 5) begin bad++; $display("FAIL %s dpc1 latency got=%0d want=5", name, l1); end
        total++; if (l2 != 3) begin bad++; $display("FAIL %s dpc2 latency got=%0d want=3", name, l2); end
        total++; if (l5 != 1) begin bad++; $display("FAIL %s dpc5 latency got=%0d want=1", name, l5); end
    endtask

    task automatic test_signed();
        total++; if (ref_mul(8'h80, 8'h80, 1'b0, 1'b0) !== 16'h4000) begin bad++; $display("FAIL model_ss got=%h want=4000", ref_mul(8'h80, 8'h80, 1'b0, 1'b0)); end
        check_op("ss_80x80", 8'h80, 8'h80, 1'b0, 1'b0);
        check_op("ss_7fx80", 8'h7F, 8'h80, 1'b0, 1'b0);
    endtask

    task automatic test_unsigned();
        check_op("uu_ffxff", 8'hFF, 8'hFF, 1'b1, 1'b1);
        check_op("uu_00xff", 8'h00, 8'hFF, 1'b1, 1'b1);
    endtask

    task automatic test_mixed();
        check_op("su_ffxff", 8'hFF, 8'hFF, 1'b0, 1'b1);
        check_op("us_ffxff", 8'hFF, 8'hFF, 1'b1, 1'b0);
    endtask

    task automatic test_dpc();
        check_op("dpc_05x03", 8'h05, 8'h03, 1'b0, 1'b0);
    endtask

    task automatic test_backpressure();
        logic [15:0] exp;
        int c;
        exp = ref_mul(8'hA5, 8'h3C, 1'b0, 1'b0);
        accept(8'hA5, 8'h3C, 1'b0, 1'b0);
        c = 0;
        while (!vld1 && c < 20) begin tick(); c++; end
        total++; if (c != 5) begin bad++; $display("FAIL bp_latency got=%0d want=5", c); end
        for (int i = 0; i < 10; i++) begin
            tick();
            total++;
            if (vld1 !== 1'b1 || prod1 !== exp || rdy1 !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold cyc=%0d got vld=%b prod=%h rdy=%b want vld=1 prod=%h rdy=0",
                         i, vld1, prod1, rdy1, exp);
            end
        end
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
        total++; if (rdy1 !== 1'b1 || vld1 !== 1'b0) begin bad++; $display("FAIL bp_release got rdy=%b vld=%b want rdy=1 vld=0", rdy1, vld1); end
    endtask

    task automatic test_flush();
        int seen;
        accept(8'h33, 8'h44, 1'b0, 1'b0);
        tick();
        tick();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        total++; if (rdy1 !== 1'b1 || vld1 !== 1'b0) begin bad++; $display("FAIL flush_idle got rdy=%b vld=%b want rdy=1 vld=0", rdy1, vld1); end
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (vld1 || vld2 || vld5) seen++;
        end
        total++; if (seen != 0) begin bad++; $display("FAIL flush_no_valid got=%0d pulses want=0", seen); end
        // Request together with flush must not be taken
        a_i = 8'h11; b_i = 8'h22; in_valid_i = 1'b1; flush_i = 1'b1;
        tick();
        in_valid_i = 1'b0; flush_i = 1'b0;
        total++; if (rdy1 !== 1'b1) begin bad++; $display("FAIL flush_priority got rdy=%b want=1", rdy1); end
        check_op("post_flush", 8'hC3, 8'h5A, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid();
        int seen;
        check_op("pre_reset", 8'h12, 8'h34, 1'b1, 1'b1);
        accept(8'h56, 8'h78, 1'b0, 1'b0);
        tick();
        #2;
        rst_ni = 1'b0;
        #1;
        total++;
        if (rdy1 !== 1'b1 || vld1 !== 1'b0 || prod1 !== 16'h0) begin
            bad++;
            $display("FAIL async_reset got rdy=%b vld=%b prod=%h want rdy=1 vld=0 prod=0000", rdy1, vld1, prod1);
        end
        tick();
        rst_ni = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (vld1 || vld2 || vld5) seen++;
        end
        total++; if (seen != 0) begin bad++; $display("FAIL reset_no_valid got=%0d pulses want=0", seen); end
    endtask

    task automatic test_random();
        logic [7:0] a, b;
        logic au, bu;
        logic [15:0] p1, p2, p5, exp;
        int l1, l2, l5;
        for (int n = 0; n < 3000; n++) begin
            a  = 8'($urandom);
            b  = 8'($urandom);
            au = 1'($urandom);
            bu = 1'($urandom);
            exp = ref_mul(a, b, au, bu);
            run_op(a, b, au, bu, p1, p2, p5, l1, l2, l5);
            total++;
            if (p1 !== exp || p2 !== exp || p5 !== exp || l1 != 5 || l2 != 3 || l5 != 1) begin
                bad++;
                $display("FAIL random a=%h b=%h au=%b bu=%b got=%h/%h/%h lat=%0d/%0d/%0d want=%h lat=5/3/1",
                         a, b, au, bu, p1, p2, p5, l1, l2, l5, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_signed();
        test_unsigned();
        test_mixed();
        test_dpc();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
